bp_me_burst_channel_monitor: RTL and testbench
==============================================

// Module: bp_me_burst_channel_monitor
// PURPOSE
//  Passive per-channel protocol monitor and statistics block for BedRock burst (header+data) channels.
//  Snoops N ready&valid channels, counts header and data beats, and checks beat count against the header size.
//  Tracks outstanding request/response balance and flags stalled bursts via a watchdog.
//  Sits beside a CCE or LCE on the LCE/mem ports; it drives no handshake signals.
// PARAMETERS
//  num_ch_p          4     number of monitored burst channels
//  data_width_p      64    data beat width in bits (power of 2, >=64)
//  block_width_p     512   maximum message payload width in bits; size field saturates here
//  size_width_p      3     header msg_size width; message bytes = 1<<size
//  timeout_p         1024  max cycles without a data beat while a burst is open
//  cnt_width_p       32    width of statistics counters
//  req_ch_p          0     channel index whose headers open a transaction
//  resp_ch_p         1     channel index whose headers close a transaction
//  max_out_p         8     max legal outstanding transactions
// PORTS
//  clk_i          in   1                      clock
//  reset_i        in   1                      reset, asynchronous, active-low
//  clear_i        in   1                      sync clear of sticky errors and counters
//  hdr_v_i        in   num_ch_p               header valid per channel
//  hdr_ready_i    in   num_ch_p               header ready_and per channel
//  hdr_size_i     in   num_ch_p*size_width_p  decoded msg_size per channel
//  hdr_has_data_i in   num_ch_p               header carries data beats
//  data_v_i       in   num_ch_p               data valid per channel
//  data_ready_i   in   num_ch_p               data ready_and per channel
//  busy_o         out  num_ch_p               burst open (data beats pending)
//  err_o          out  num_ch_p*4             sticky {stall,overlap,orphan,early} per channel
//  out_err_o      out  2                      sticky {overflow,underflow} of outstanding count
//  outstanding_o  out  lg(max_out_p+1)        outstanding transaction count
//  hdr_cnt_o      out  num_ch_p*cnt_width_p   headers accepted per channel
//  beat_cnt_o     out  num_ch_p*cnt_width_p   data beats accepted per channel
// BEHAVIOUR
//  Reset: all outputs 0, FSMs in IDLE, counters and watchdogs 0. Outputs are registered; every status reflects
//   handshakes one cycle later.
//  Handshake: hs_hdr = hdr_v_i & hdr_ready_i and hs_data = data_v_i & data_ready_i, per channel.
//  expected beats = max(1, (8<<min(size,lg(block_width_p/8)))/data_width_p). Width is lg(block_width_p/data_width_p)+1.
//  FSM per channel: IDLE, DATA.
//   IDLE + hs_hdr & has_data: load beats_left=expected. A same-cycle hs_data counts as the first beat.
//    If expected==1 and a beat is taken, stay in IDLE; otherwise go to DATA.
//   IDLE + hs_hdr & ~has_data: stay in IDLE.
//   IDLE + hs_data without hs_hdr: set orphan error; beat still counted.
//   DATA + hs_data: beats_left--. When it reaches 0, go to IDLE.
//   DATA + hs_hdr: set overlap error; restart the burst with the new header's expected count.
//   early error: has_data header on a channel whose previous burst was cut by overlap (beats_left>0 at restart).
//  Watchdog: counts DATA cycles with no hs_data; resets on a beat or on leaving DATA.
//   At timeout_p it sets the stall error (sticky) and holds the count; the FSM stays in DATA.
//  Outstanding: +1 on hs_hdr[req_ch_p], -1 on hs_hdr[resp_ch_p]; a simultaneous +1/-1 is a net 0.
//   Increment at max_out_p: set overflow, hold the value. Decrement at 0: set underflow, hold 0.
//  Counters saturate at all-ones and never wrap.
//  clear_i: zeroes errors and counters. FSM state, beats_left and outstanding are untouched.
//   A same-cycle error event wins over clear_i.
//  Reset mid-burst: everything returns to the reset values immediately (async); no error is flagged.
//  busy_o = (state==DATA).
// STRUCTURE
//  bp_me_monitor_pkg: state enum {e_mon_idle,e_mon_data}; error bit index constants (e_err_early..e_err_stall);
//   beats-from-size function.
//  Sub-module bp_me_burst_channel_fsm: one channel FSM, watchdog and counters; instantiated num_ch_p times in a generate.
//  Top level: generate loop plus the outstanding tracker.
// TESTING
//  1. size=6 (64B), has_data, data_width 64, 8 beats back-to-back -> busy 8 cycles, beat_cnt=8, hdr_cnt=1, no err.
//  2. size=3 header with a same-cycle data beat -> busy never set, beat_cnt=1, no err.
//  3. Data beat on ch2 with no header -> err_o[ch2].orphan=1 next cycle, beat_cnt[2]=1.
//  4. 8-beat burst, 3 beats then a new header -> overlap=1, early=1, beats_left reloaded to 8.
//  5. Open burst held idle 1024 cycles -> stall=1 at cycle 1024, busy stays 1; clear_i -> err 0, busy 1.
//  6. 8 req headers then a 9th -> overflow=1, outstanding=8; simultaneous req+resp -> 8; 9 resps -> underflow=1, outstanding=0.

Source files
------------

// File: rtl/bp_me_monitor_pkg.sv
// Shared types and helpers for the BedRock burst channel monitor.
`timescale 1ns/1ps
package bp_me_monitor_pkg;

    // Per-channel burst tracking state
    typedef enum logic {
        e_mon_idle = 1'b0,
        e_mon_data = 1'b1
    } bp_me_mon_state_e;

    // Bit positions inside each channel's 4-bit error field
    localparam int e_err_early   = 0;
    localparam int e_err_orphan  = 1;
    localparam int e_err_overlap = 2;
    localparam int e_err_stall   = 3;
    localparam int mon_err_width_lp = 4;

    // Number of data beats a header of the given msg_size carries.
    // The size is saturated at the block size; messages narrower than
    // one beat still occupy a single beat. Only shifts are used so the
    // logic stays cheap when the size is a live signal.
    function automatic int unsigned mon_beats_from_size(
        input int unsigned size,
        input int unsigned lg_max_bytes,
        input int unsigned lg_data_bits
    );
        int unsigned lg_bytes;
        int unsigned lg_bits;
        lg_bytes = (size > lg_max_bytes) ? lg_max_bytes : size;
        lg_bits  = lg_bytes + 32'd3;
        if (lg_bits <= lg_data_bits) begin
            return 32'd1;
        end
        return 32'd1 << (lg_bits - lg_data_bits);
    endfunction

endpackage

// File: rtl/bp_me_burst_channel_fsm.sv
// One monitored burst channel: IDLE/DATA tracker, stall watchdog,
// sticky protocol errors and saturating header/beat counters.
`timescale 1ns/1ps
module bp_me_burst_channel_fsm
    import bp_me_monitor_pkg::*;
#(
    parameter int data_width_p  = 64,
    parameter int block_width_p = 512,
    parameter int size_width_p  = 3,
    parameter int timeout_p     = 1024,
    parameter int cnt_width_p   = 32
)
(
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        clear_i,
    input  logic                        hdr_v_i,
    input  logic                        hdr_ready_i,
    input  logic [size_width_p-1:0]     hdr_size_i,
    input  logic                        hdr_has_data_i,
    input  logic                        data_v_i,
    input  logic                        data_ready_i,
    output logic                        busy_o,
    output logic [mon_err_width_lp-1:0] err_o,
    output logic [cnt_width_p-1:0]      hdr_cnt_o,
    output logic [cnt_width_p-1:0]      beat_cnt_o
);

    localparam int unsigned lg_max_bytes_lp = $clog2(block_width_p / 8);
    localparam int unsigned lg_data_bits_lp = $clog2(data_width_p);
    localparam int beats_width_lp = $clog2(block_width_p / data_width_p) + 1;
    localparam int wd_width_lp    = $clog2(timeout_p + 1);
    localparam logic [wd_width_lp-1:0] wd_max_lp = wd_width_lp'(timeout_p);
    localparam logic [wd_width_lp-1:0] wd_pre_lp = wd_width_lp'(timeout_p - 1);

    bp_me_mon_state_e             state_q, state_d;
    logic [beats_width_lp-1:0]    beats_left_q, beats_left_d;
    logic [wd_width_lp-1:0]       wd_q, wd_d;
    logic [mon_err_width_lp-1:0]  err_q, err_d;
    logic [cnt_width_p-1:0]       hdr_cnt_q, hdr_cnt_d;
    logic [cnt_width_p-1:0]       beat_cnt_q, beat_cnt_d;

    logic                         hs_hdr;
    logic                         hs_data;
    logic                         hdr_burst;
    logic [beats_width_lp-1:0]    exp_beats;
    logic [beats_width_lp-1:0]    load_left;
    bp_me_mon_state_e             load_state;
    logic [mon_err_width_lp-1:0]  err_evt;
    logic                         stall_evt;

    assign hs_hdr    = hdr_v_i & hdr_ready_i;
    assign hs_data   = data_v_i & data_ready_i;
    assign hdr_burst = hs_hdr & hdr_has_data_i;
    assign exp_beats = beats_width_lp'(mon_beats_from_size(32'(hdr_size_i),
                                                           lg_max_bytes_lp,
                                                           lg_data_bits_lp));

    // Burst tracker: opens on a data-carrying header, closes on the last beat
    always_comb begin
        state_d      = state_q;
        beats_left_d = beats_left_q;
        err_evt      = '0;
        // A beat accepted alongside the header is the burst's first beat
        load_left    = hs_data ? (exp_beats - beats_width_lp'(1)) : exp_beats;
        load_state   = (load_left == '0) ? e_mon_idle : e_mon_data;
        case (state_q)
            e_mon_idle: begin
                if (hdr_burst) begin
                    state_d      = load_state;
                    beats_left_d = load_left;
                end else if (hs_data) begin
                    err_evt[e_err_orphan] = 1'b1;
                end
            end
            e_mon_data: begin
                if (hs_hdr) begin
                    err_evt[e_err_overlap] = 1'b1;
                    if (hdr_has_data_i) begin
                        // The cut burst still owed beats: the new one came early
                        err_evt[e_err_early] = (beats_left_q != '0);
                        state_d      = load_state;
                        beats_left_d = load_left;
                    end else begin
                        state_d      = e_mon_idle;
                        beats_left_d = '0;
                    end
                end else if (hs_data) begin
                    beats_left_d = beats_left_q - beats_width_lp'(1);
                    if (beats_left_q == beats_width_lp'(1)) begin
                        state_d = e_mon_idle;
                    end
                end
            end
        endcase
    end

    // Watchdog: counts beat-less cycles of an open burst and saturates at the limit
    always_comb begin
        wd_d      = '0;
        stall_evt = 1'b0;
        if ((state_q == e_mon_data) && (state_d == e_mon_data) && !hs_data) begin
            wd_d      = (wd_q == wd_max_lp) ? wd_q : (wd_q + wd_width_lp'(1));
            stall_evt = (wd_q == wd_pre_lp);
        end
    end

    // Sticky errors (a new event beats clear) and saturating statistics counters
    always_comb begin
        err_d = clear_i ? '0 : err_q;
        err_d = err_d | err_evt;
        if (stall_evt) begin
            err_d[e_err_stall] = 1'b1;
        end
        hdr_cnt_d  = clear_i ? '0 : hdr_cnt_q;
        beat_cnt_d = clear_i ? '0 : beat_cnt_q;
        if (hs_hdr && (hdr_cnt_d != '1)) begin
            hdr_cnt_d = hdr_cnt_d + cnt_width_p'(1);
        end
        if (hs_data && (beat_cnt_d != '1)) begin
            beat_cnt_d = beat_cnt_d + cnt_width_p'(1);
        end
    end

    // State registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q      <= e_mon_idle;
            beats_left_q <= '0;
            wd_q         <= '0;
            err_q        <= '0;
            hdr_cnt_q    <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            beats_left_q <= beats_left_d;
            wd_q         <= wd_d;
            err_q        <= err_d;
            hdr_cnt_q    <= hdr_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign busy_o     = (state_q == e_mon_data);
    assign err_o      = err_q;
    assign hdr_cnt_o  = hdr_cnt_q;
    assign beat_cnt_o = beat_cnt_q;

endmodule

// File: rtl/bp_me_burst_channel_monitor.sv
// Passive monitor for N BedRock burst channels: per-channel protocol
// trackers plus a request/response outstanding-transaction balance.
`timescale 1ns/1ps
module bp_me_burst_channel_monitor
    import bp_me_monitor_pkg::*;
#(
    parameter int num_ch_p      = 4,
    parameter int data_width_p  = 64,
    parameter int block_width_p = 512,
    parameter int size_width_p  = 3,
    parameter int timeout_p     = 1024,
    parameter int cnt_width_p   = 32,
    parameter int req_ch_p      = 0,
    parameter int resp_ch_p     = 1,
    parameter int max_out_p     = 8
)
(
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic                                 clear_i,
    input  logic [num_ch_p-1:0]                  hdr_v_i,
    input  logic [num_ch_p-1:0]                  hdr_ready_i,
    input  logic [num_ch_p*size_width_p-1:0]     hdr_size_i,
    input  logic [num_ch_p-1:0]                  hdr_has_data_i,
    input  logic [num_ch_p-1:0]                  data_v_i,
    input  logic [num_ch_p-1:0]                  data_ready_i,
    output logic [num_ch_p-1:0]                  busy_o,
    output logic [num_ch_p*mon_err_width_lp-1:0] err_o,
    output logic [1:0]                           out_err_o,
    output logic [$clog2(max_out_p+1)-1:0]       outstanding_o,
    output logic [num_ch_p*cnt_width_p-1:0]      hdr_cnt_o,
    output logic [num_ch_p*cnt_width_p-1:0]      beat_cnt_o
);

    localparam int out_width_lp = $clog2(max_out_p + 1);
    localparam logic [out_width_lp-1:0] out_max_lp = out_width_lp'(max_out_p);

    // One independent tracker per channel
    for (genvar gi = 0; gi < num_ch_p; gi++) begin : g_ch
        bp_me_burst_channel_fsm #(
            .data_width_p  (data_width_p),
            .block_width_p (block_width_p),
            .size_width_p  (size_width_p),
            .timeout_p     (timeout_p),
            .cnt_width_p   (cnt_width_p)
        ) u_fsm (
            .clk_i          (clk_i),
            .reset_i        (reset_i),
            .clear_i        (clear_i),
            .hdr_v_i        (hdr_v_i[gi]),
            .hdr_ready_i    (hdr_ready_i[gi]),
            .hdr_size_i     (hdr_size_i[gi*size_width_p +: size_width_p]),
            .hdr_has_data_i (hdr_has_data_i[gi]),
            .data_v_i       (data_v_i[gi]),
            .data_ready_i   (data_ready_i[gi]),
            .busy_o         (busy_o[gi]),
            .err_o          (err_o[gi*mon_err_width_lp +: mon_err_width_lp]),
            .hdr_cnt_o      (hdr_cnt_o[gi*cnt_width_p +: cnt_width_p]),
            .beat_cnt_o     (beat_cnt_o[gi*cnt_width_p +: cnt_width_p])
        );
    end

    logic [out_width_lp-1:0] outstanding_q, outstanding_d;
    logic [1:0]              out_err_q, out_err_d;
    logic [1:0]              out_evt;
    logic                    out_inc;
    logic                    out_dec;

    assign out_inc = hdr_v_i[req_ch_p]  & hdr_ready_i[req_ch_p];
    assign out_dec = hdr_v_i[resp_ch_p] & hdr_ready_i[resp_ch_p];

    // Outstanding balance: saturates at both ends and flags the offending edge
    always_comb begin
        outstanding_d = outstanding_q;
        out_evt       = '0;
        if (out_inc && !out_dec) begin
            if (outstanding_q == out_max_lp) begin
                out_evt[1] = 1'b1;
            end else begin
                outstanding_d = outstanding_q + out_width_lp'(1);
            end
        end else if (out_dec && !out_inc) begin
            if (outstanding_q == '0) begin
                out_evt[0] = 1'b1;
            end else begin
                outstanding_d = outstanding_q - out_width_lp'(1);
            end
        end
        out_err_d = (clear_i ? 2'b00 : out_err_q) | out_evt;
    end

    // Outstanding tracker registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            outstanding_q <= '0;
            out_err_q     <= '0;
        end else begin
            outstanding_q <= outstanding_d;
            out_err_q     <= out_err_d;
        end
    end

    assign outstanding_o = outstanding_q;
    assign out_err_o     = out_err_q;

endmodule

// File: tb/tb_bp_me_burst_channel_monitor.sv
// Directed self-checking bench for bp_me_burst_channel_monitor.
`timescale 1ns/1ps
module tb_bp_me_burst_channel_monitor;

    localparam int NCH = 4;
    localparam int SW  = 3;
    localparam int CW  = 32;

    logic                clk_i = 1'b0;
    logic                reset_i;
    logic                clear_i;
    logic [NCH-1:0]      hdr_v_i;
    logic [NCH-1:0]      hdr_ready_i;
    logic [NCH*SW-1:0]   hdr_size_i;
    logic [NCH-1:0]      hdr_has_data_i;
    logic [NCH-1:0]      data_v_i;
    logic [NCH-1:0]      data_ready_i;
    logic [NCH-1:0]      busy_o;
    logic [NCH*4-1:0]    err_o;
    logic [1:0]          out_err_o;
    logic [3:0]          outstanding_o;
    logic [NCH*CW-1:0]   hdr_cnt_o;
    logic [NCH*CW-1:0]   beat_cnt_o;

    int errors = 0;
    int checks = 0;

    bp_me_burst_channel_monitor dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .clear_i        (clear_i),
        .hdr_v_i        (hdr_v_i),
        .hdr_ready_i    (hdr_ready_i),
        .hdr_size_i     (hdr_size_i),
        .hdr_has_data_i (hdr_has_data_i),
        .data_v_i       (data_v_i),
        .data_ready_i   (data_ready_i),
        .busy_o         (busy_o),
        .err_o          (err_o),
        .out_err_o      (out_err_o),
        .outstanding_o  (outstanding_o),
        .hdr_cnt_o      (hdr_cnt_o),
        .beat_cnt_o     (beat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "timeout");
    end

    function automatic logic [3:0] err_of(input int ch);
        return err_o[ch*4 +: 4];
    endfunction
    function automatic logic [CW-1:0] hcnt(input int ch);
        return hdr_cnt_o[ch*CW +: CW];
    endfunction
    function automatic logic [CW-1:0] bcnt(input int ch);
        return beat_cnt_o[ch*CW +: CW];
    endfunction

    task automatic idle_in();
        hdr_v_i        = '0;
        hdr_has_data_i = '0;
        hdr_size_i     = '0;
        data_v_i       = '0;
        hdr_ready_i    = '1;
        data_ready_i   = '1;
        clear_i        = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_hdr(input int ch, input logic [2:0] sz, input logic hd);
        hdr_v_i[ch]            = 1'b1;
        hdr_has_data_i[ch]     = hd;
        hdr_size_i[ch*SW +: SW] = sz;
    endtask

    task automatic do_clear();
        clear_i = 1'b1;
        tick();
        idle_in();
    endtask

    task automatic test_reset();
        idle_in();
        reset_i = 1'b1;
        #2 reset_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        checks++; if (busy_o !== '0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (err_o !== '0) begin errors++; $display("FAIL reset_err: got %h want 0", err_o); end
        checks++; if (out_err_o !== 2'b00 || outstanding_o !== 4'd0) begin errors++;
            $display("FAIL reset_out: got err=%b out=%0d want 0/0", out_err_o, outstanding_o); end
        checks++; if (hdr_cnt_o !== '0 || beat_cnt_o !== '0) begin errors++; $display("FAIL reset_cnt: got nonzero want 0"); end
        @(negedge clk_i);
        reset_i = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_burst();
        int busy_cycles;
        busy_cycles = 0;
        send_hdr(3, 3'd6, 1'b1);
        tick(); idle_in();
        if (busy_o[3]) busy_cycles++;
        for (int i = 0; i < 8; i++) begin
            data_v_i[3] = 1'b1;
            tick(); idle_in();
            if (busy_o[3]) busy_cycles++;
        end
        checks++; if (busy_cycles != 8) begin errors++; $display("FAIL burst_busy_cycles: got %0d want 8", busy_cycles); end
        checks++; if (busy_o[3] !== 1'b0) begin errors++; $display("FAIL burst_busy_end: got %b want 0", busy_o[3]); end
        checks++; if (bcnt(3) !== 32'd8) begin errors++; $display("FAIL burst_beat_cnt: got %0d want 8", bcnt(3)); end
        checks++; if (hcnt(3) !== 32'd1) begin errors++; $display("FAIL burst_hdr_cnt: got %0d want 1", hcnt(3)); end
        checks++; if (err_o !== '0) begin errors++; $display("FAIL burst_err: got %h want 0", err_o); end
        $display("test_burst: busy_cycles=%0d beats=%0d", busy_cycles, bcnt(3));
    endtask

    task automatic test_single_beat();
        do_clear();
        send_hdr(3, 3'd3, 1'b1);
        data_v_i[3] = 1'b1;
        tick(); idle_in();
        checks++; if (busy_o[3] !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy_o[3]); end
        checks++; if (bcnt(3) !== 32'd1) begin errors++; $display("FAIL single_beat_cnt: got %0d want 1", bcnt(3)); end
        checks++; if (hcnt(3) !== 32'd1) begin errors++; $display("FAIL single_hdr_cnt: got %0d want 1", hcnt(3)); end
        tick();
        checks++; if (busy_o[3] !== 1'b0 || err_o !== '0) begin errors++;
            $display("FAIL single_after: got busy=%b err=%h want 0/0", busy_o[3], err_o); end
        $display("test_single_beat: beats=%0d", bcnt(3));
    endtask

    task automatic test_orphan();
        do_clear();
        data_v_i[2] = 1'b1;
        data_ready_i[2] = 1'b0;
        tick(); idle_in();
        checks++; if (err_of(2) !== 4'b0000 || bcnt(2) !== 32'd0) begin errors++;
            $display("FAIL orphan_not_ready: got err=%b cnt=%0d want 0000/0", err_of(2), bcnt(2)); end
        data_v_i[2] = 1'b1;
        tick(); idle_in();
        checks++; if (err_of(2) !== 4'b0010) begin errors++; $display("FAIL orphan_err: got %b want 0010", err_of(2)); end
        checks++; if (bcnt(2) !== 32'd1) begin errors++; $display("FAIL orphan_beat_cnt: got %0d want 1", bcnt(2)); end
        checks++; if (busy_o[2] !== 1'b0) begin errors++; $display("FAIL orphan_busy: got %b want 0", busy_o[2]); end
        $display("test_orphan: err=%b", err_of(2));
    endtask

    task automatic test_sizes();
        logic [2:0] sz_tab  [4] = '{3'd5, 3'd7, 3'd4, 3'd0};
        int         exp_tab [4] = '{4, 8, 2, 1};
        int beats;
        do_clear();
        for (int k = 0; k < 4; k++) begin
            beats = 0;
            send_hdr(3, sz_tab[k], 1'b1);
            tick(); idle_in();
            for (int j = 0; j < 16 && busy_o[3]; j++) begin
                data_v_i[3] = 1'b1;
                tick(); idle_in();
                beats++;
            end
            checks++; if (beats != exp_tab[k] || busy_o[3] !== 1'b0) begin errors++;
                $display("FAIL size_beats: size=%0d got %0d busy=%b want %0d/0", sz_tab[k], beats, busy_o[3], exp_tab[k]); end
            $display("test_sizes: size=%0d beats=%0d", sz_tab[k], beats);
        end
        checks++; if (err_o !== '0) begin errors++; $display("FAIL size_err: got %h want 0", err_o); end
    endtask

    task automatic test_overlap();
        logic held;
        do_clear();
        send_hdr(3, 3'd6, 1'b1);
        tick(); idle_in();
        for (int i = 0; i < 3; i++) begin
            data_v_i[3] = 1'b1;
            tick(); idle_in();
        end
        send_hdr(3, 3'd6, 1'b1);
        tick(); idle_in();
        checks++; if (err_of(3) !== 4'b0101) begin errors++; $display("FAIL overlap_err: got %b want 0101", err_of(3)); end
        checks++; if (busy_o[3] !== 1'b1) begin errors++; $display("FAIL overlap_busy: got %b want 1", busy_o[3]); end
        held = 1'b1;
        for (int i = 0; i < 7; i++) begin
            data_v_i[3] = 1'b1;
            tick(); idle_in();
            held = held & busy_o[3];
        end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL overlap_reload: got busy dropped want held 7 beats"); end
        data_v_i[3] = 1'b1;
        tick(); idle_in();
        checks++; if (busy_o[3] !== 1'b0) begin errors++; $display("FAIL overlap_close: got %b want 0", busy_o[3]); end
        checks++; if (bcnt(3) !== 32'd11 || hcnt(3) !== 32'd2) begin errors++;
            $display("FAIL overlap_cnt: got beats=%0d hdrs=%0d want 11/2", bcnt(3), hcnt(3)); end
        $display("test_overlap: err=%b beats=%0d", err_of(3), bcnt(3));
    endtask

    task automatic test_stall();
        do_clear();
        checks++; if (err_o !== '0) begin errors++; $display("FAIL clear_err: got %h want 0", err_o); end
        send_hdr(3, 3'd6, 1'b1);
        tick(); idle_in();
        repeat (1023) tick();
        checks++; if (err_of(3) !== 4'b0000 || busy_o[3] !== 1'b1) begin errors++;
            $display("FAIL stall_early: got err=%b busy=%b want 0000/1", err_of(3), busy_o[3]); end
        tick();
        checks++; if (err_of(3) !== 4'b1000 || busy_o[3] !== 1'b1) begin errors++;
            $display("FAIL stall_set: got err=%b busy=%b want 1000/1", err_of(3), busy_o[3]); end
        tick();
        do_clear();
        checks++; if (err_of(3) !== 4'b0000 || busy_o[3] !== 1'b1 || hcnt(3) !== 32'd0) begin errors++;
            $display("FAIL stall_clear: got err=%b busy=%b hdrs=%0d want 0000/1/0", err_of(3), busy_o[3], hcnt(3)); end
        tick();
        checks++; if (err_of(3) !== 4'b0000) begin errors++; $display("FAIL stall_hold: got %b want 0000", err_of(3)); end
        for (int i = 0; i < 8; i++) begin
            data_v_i[3] = 1'b1;
            tick(); idle_in();
        end
        checks++; if (busy_o[3] !== 1'b0) begin errors++; $display("FAIL stall_finish: got %b want 0", busy_o[3]); end
        $display("test_stall: err=%b busy=%b", err_of(3), busy_o[3]);
    endtask

    task automatic test_outstanding();
        do_clear();
        for (int i = 1; i <= 8; i++) begin
            send_hdr(0, 3'd0, 1'b0);
            tick(); idle_in();
            checks++; if (outstanding_o !== 4'(i) || out_err_o !== 2'b00) begin errors++;
                $display("FAIL out_inc: got %0d err=%b want %0d/00", outstanding_o, out_err_o, i); end
        end
        send_hdr(0, 3'd0, 1'b0);
        tick(); idle_in();
        checks++; if (outstanding_o !== 4'd8 || out_err_o !== 2'b10) begin errors++;
            $display("FAIL out_overflow: got %0d err=%b want 8/10", outstanding_o, out_err_o); end
        send_hdr(0, 3'd0, 1'b0);
        send_hdr(1, 3'd0, 1'b0);
        tick(); idle_in();
        checks++; if (outstanding_o !== 4'd8 || out_err_o !== 2'b10) begin errors++;
            $display("FAIL out_both: got %0d err=%b want 8/10", outstanding_o, out_err_o); end
        for (int i = 1; i <= 8; i++) begin
            send_hdr(1, 3'd0, 1'b0);
            tick(); idle_in();
            checks++; if (outstanding_o !== 4'(8 - i)) begin errors++;
                $display("FAIL out_dec: got %0d want %0d", outstanding_o, 8 - i); end
        end
        send_hdr(1, 3'd0, 1'b0);
        tick(); idle_in();
        checks++; if (outstanding_o !== 4'd0 || out_err_o !== 2'b11) begin errors++;
            $display("FAIL out_underflow: got %0d err=%b want 0/11", outstanding_o, out_err_o); end
        checks++; if (hcnt(0) !== 32'd10 || hcnt(1) !== 32'd10) begin errors++;
            $display("FAIL out_hdr_cnt: got %0d/%0d want 10/10", hcnt(0), hcnt(1)); end
        $display("test_outstanding: out=%0d err=%b", outstanding_o, out_err_o);
    endtask

    task automatic test_reset_midburst();
        send_hdr(3, 3'd6, 1'b1);
        send_hdr(0, 3'd0, 1'b0);
        tick(); idle_in();
        checks++; if (busy_o[3] !== 1'b1 || outstanding_o !== 4'd1) begin errors++;
            $display("FAIL midrst_pre: got busy=%b out=%0d want 1/1", busy_o[3], outstanding_o); end
        #2 reset_i = 1'b0;
        #1;
        checks++; if (busy_o !== '0 || outstanding_o !== 4'd0 || out_err_o !== 2'b00) begin errors++;
            $display("FAIL midrst_async: got busy=%b out=%0d oerr=%b want 0/0/00", busy_o, outstanding_o, out_err_o); end
        checks++; if (err_o !== '0 || hdr_cnt_o !== '0 || beat_cnt_o !== '0) begin errors++;
            $display("FAIL midrst_clear: got err=%h want 0 and zero counters", err_o); end
        @(negedge clk_i);
        reset_i = 1'b1;
        tick();
        checks++; if (busy_o !== '0 || err_o !== '0) begin errors++;
            $display("FAIL midrst_after: got busy=%b err=%h want 0/0", busy_o, err_o); end
        $display("test_reset_midburst: busy=%b", busy_o);
    endtask

    initial begin
        test_reset();
        test_burst();
        test_single_beat();
        test_orphan();
        test_sizes();
        test_overlap();
        test_stall();
        test_outstanding();
        test_reset_midburst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
